// File: rtl/inert_cal_seq.sv
// Calibration sequencer and LED status/display controller for inertial interface bring-up.
// Issues start pulses with bounded retries, then shows the heading or a failure blink.
module inert_cal_seq #(
    parameter int          HEAD_W    = 12,
    parameter int          LED_W     = 8,
    parameter logic [31:0] CAL_PAT   = 32'h0000_00A5,
    parameter int          CAL_TMO   = 50_000_000,
    parameter int          MAX_RETRY = 2,
    parameter int          BLINK_DIV = 12_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cal_done,
    input  logic [HEAD_W-1:0] heading,
    input  logic              mode_btn,
    input  logic              recal,
    output logic              strt_cal,
    output logic              cal_fail,
    output logic [1:0]        disp_mode,
    output logic [LED_W-1:0]  LED
);

    localparam int TW = (CAL_TMO > 1) ? $clog2(CAL_TMO) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]    TMO_LAST   = TW'(CAL_TMO - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [LED_W-1:0] CAL_LED    = LED_W'(CAL_PAT);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CAL  = 3'd1;
    localparam logic [2:0] DISP = 3'd2;
    localparam logic [2:0] FAIL = 3'd3;

    logic [2:0]       state;
    logic [TW-1:0]    tmo_cnt;
    logic [RW-1:0]    retry;
    logic [BW-1:0]    blink_cnt;
    logic             blink_phase;
    logic [LED_W-1:0] snapshot;

    // Blink state restarts on every entry into FAIL so the first half-period is always dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            retry       <= '0;
            disp_mode   <= 2'd0;
            snapshot    <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (recal) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            retry       <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= CAL;
                    tmo_cnt <= '0;
                end
                CAL: begin
                    if (cal_done) begin
                        state <= DISP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= FAIL;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DISP: begin
                    if (mode_btn) begin
                        if (disp_mode == 2'd1) begin
                            snapshot <= heading[HEAD_W-1 -: LED_W];
                        end
                        disp_mode <= (disp_mode >= 2'd2) ? 2'd0 : disp_mode + 2'd1;
                    end
                end
                FAIL: begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt   <= blink_cnt + 1'b1;
                        blink_phase <= blink_phase;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign strt_cal = !rst && (state == IDLE);
    assign cal_fail = (state == FAIL);

    always_comb begin
        LED = CAL_LED;
        case (state)
            DISP: begin
                case (disp_mode)
                    2'd1:    LED = heading[LED_W-1:0];
                    2'd2:    LED = snapshot;
                    default: LED = heading[HEAD_W-1 -: LED_W];
                endcase
            end
            FAIL:    LED = {LED_W{blink_phase}};
            default: LED = CAL_LED;
        endcase
    end

endmodule
